// File: rtl/sonar_sweep_uc.sv
// Sonar sweep control unit.
// Steps the servo through N_POS positions (wrap-around or ping-pong), waits for
// the servo to settle, triggers one ultrasonic measurement guarded by a timeout,
// then streams N_CHARS characters to the serial transmitter over a start/done
// handshake. db_estado exposes the state code for debug.
module sonar_sweep_uc #(
  parameter int N_POS          = 8,
  parameter int POS_W          = 3,
  parameter int N_CHARS        = 8,
  parameter int SEL_W          = 3,
  parameter int WAIT_CYCLES    = 100_000_000,
  parameter int TIMEOUT_CYCLES = 2_500_000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ligar,
  input  logic             modo,
  input  logic             sensor_pronto,
  input  logic             serial_pronto,
  output logic [POS_W-1:0] posicao,
  output logic             medir,
  output logic             partida,
  output logic [SEL_W-1:0] sel,
  output logic             erro,
  output logic             pronto_ciclo,
  output logic [3:0]       db_estado
);

  // Counters only need to reach their parameter minus one before the state moves on.
  localparam int WAIT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int TMO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_CYCLES - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(N_POS - 1);
  localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(N_CHARS - 1);

  typedef enum logic [3:0] {
    INICIAL     = 4'd0,
    PREPARACAO  = 4'd1,
    POSICIONA   = 4'd2,
    ESPERA      = 4'd3,
    MEDE        = 4'd4,
    AGUARDA_MED = 4'd5,
    TX_INICIA   = 4'd6,
    TX_AGUARDA  = 4'd7,
    PROXIMA     = 4'd8
  } estado_t;

  estado_t             estado;
  logic                modo_lat;     // sweep order latched at PREPARACAO
  logic                descendo;     // ping-pong direction: 1 = moving towards 0
  logic [WAIT_W-1:0]   cnt_espera;
  logic [TMO_W-1:0]    cnt_timeout;

  logic [POS_W-1:0]    pos_prox;
  logic                desc_prox;
  logic                fim_volta;    // leaving this position completes a sweep

  // The state register itself is the debug code, so it is registered for free.
  assign db_estado = estado;

  // Next position, next direction and end-of-sweep flag for the current position.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    pos_prox  = posicao;
    desc_prox = descendo;
    fim_volta = 1'b0;
    if (!modo_lat) begin
      if (posicao == POS_LAST) begin
        pos_prox  = '0;
        fim_volta = 1'b1;
      end else begin
        pos_prox = posicao + 1'b1;
      end
    end else if (!descendo) begin
      if (posicao == POS_LAST) begin
        pos_prox  = POS_LAST - 1'b1;
        desc_prox = 1'b1;
        fim_volta = 1'b1;
      end else begin
        pos_prox = posicao + 1'b1;
      end
    end else begin
      if (posicao == '0) begin
        pos_prox  = POS_W'(1);
        desc_prox = 1'b0;
        fim_volta = 1'b1;
      end else begin
        pos_prox = posicao - 1'b1;
      end
    end
  end

  // Sweep FSM; pulse outputs are set on the edge entering their state so they
  // coincide exactly with that state's single visit.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado       <= INICIAL;
      posicao      <= '0;
      sel          <= '0;
      medir        <= 1'b0;
      partida      <= 1'b0;
      erro         <= 1'b0;
      pronto_ciclo <= 1'b0;
      modo_lat     <= 1'b0;
      descendo     <= 1'b0;
      cnt_espera   <= '0;
      cnt_timeout  <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register here sees
      // the pre-edge values of the others regardless of statement order.
      medir        <= 1'b0;
      partida      <= 1'b0;
      pronto_ciclo <= 1'b0;
      case (estado)
        INICIAL: begin
          if (ligar) estado <= PREPARACAO;
        end
        PREPARACAO: begin
          posicao  <= '0;
          descendo <= 1'b0;
          modo_lat <= modo;
          erro     <= 1'b0;
          estado   <= POSICIONA;
        end
        POSICIONA: begin
          cnt_espera <= '0;
          estado     <= ESPERA;
        end
        ESPERA: begin
          if (cnt_espera == WAIT_LAST) begin
            medir  <= 1'b1;
            estado <= MEDE;
          end else begin
            cnt_espera <= cnt_espera + 1'b1;
          end
        end
        MEDE: begin
          cnt_timeout <= '0;
          estado      <= AGUARDA_MED;
        end
        AGUARDA_MED: begin
          // A reply in the final timeout cycle still counts as a success.
          if (sensor_pronto) begin
            erro    <= 1'b0;
            sel     <= '0;
            partida <= 1'b1;
            estado  <= TX_INICIA;
          end else if (cnt_timeout == TMO_LAST) begin
            erro    <= 1'b1;
            sel     <= '0;
            partida <= 1'b1;
            estado  <= TX_INICIA;
          end else begin
            cnt_timeout <= cnt_timeout + 1'b1;
          end
        end
        TX_INICIA: begin
          estado <= TX_AGUARDA;
        end
        TX_AGUARDA: begin
          if (serial_pronto) begin
            if (sel == SEL_LAST) begin
              pronto_ciclo <= fim_volta;
              estado       <= PROXIMA;
            end else begin
              sel     <= sel + 1'b1;
              partida <= 1'b1;
              estado  <= TX_INICIA;
            end
          end
        end
        PROXIMA: begin
          posicao  <= pos_prox;
          descendo <= desc_prox;
          estado   <= ligar ? POSICIONA : INICIAL;
        end
        default: estado <= INICIAL;
      endcase
    end
  end

endmodule
